// File: rtl/pipe_share_arbiter_if.sv
// Handshake bundle for pipe_share_arbiter: two requester ports (req/data/gnt)
// and one downstream output port (valid/ready/data/tag) plus the transfer count.
interface pipe_share_arbiter_if #(
  parameter int DW    = 4,
  parameter int CNT_W = 8
);
  logic             req0;
  logic [DW-1:0]    in0;
  logic             gnt0;
  logic             req1;
  logic [DW-1:0]    in1;
  logic             gnt1;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_tag;
  logic [CNT_W-1:0] out_count;

  // Requesters and downstream sink side
  modport master (
    output req0, in0, req1, in1, out_ready,
    input  gnt0, gnt1, out_valid, out_data, out_tag, out_count
  );

  // Arbiter / pipeline side
  modport slave (
    input  req0, in0, req1, in1, out_ready,
    output gnt0, gnt1, out_valid, out_data, out_tag, out_count
  );
endinterface

// File: rtl/pipe_share_arbiter.sv
// pipe_share_arbiter: two requesters share one elastic 2-stage register
// pipeline. Conflicts are resolved round-robin; each sample carries the index
// of the requester that produced it. Downstream backpressure stalls the pipe.
// Build option: define ARB_FIXED_PRIO_EN to give req0 fixed priority on
// conflict (the round-robin pointer is then removed and req1 can starve).
module pipe_share_arbiter #(
  parameter int            DW     = 4,
  parameter int            CNT_W  = 8,
  parameter logic [DW-1:0] S1_RST = DW'(7)
) (
  input  logic                 clk,
  input  logic                 rst,
  pipe_share_arbiter_if.slave  bus
);

  // Stage 1 and stage 2 registers
  logic             vld_p1;
  logic             tag_p1;
  logic [DW-1:0]    data_p1;
  logic             vld_p2;
  logic             tag_p2;
  logic [DW-1:0]    data_p2;
  logic [CNT_W-1:0] count;

  logic advance;
  logic accept;
  logic gnt0;
  logic gnt1;
  logic gnt_any;

`ifndef ARB_FIXED_PRIO_EN
  // Requester that wins the next conflict (0 = req0, 1 = req1)
  logic ptr;
`endif

  assign advance = !vld_p2 || bus.out_ready;
  assign accept  = !vld_p1 || advance;
  assign gnt_any = gnt0 || gnt1;

  // Grant: one-hot or zero, only when stage 1 can take a sample
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && accept) begin
      if (bus.req0 && bus.req1) begin
`ifdef ARB_FIXED_PRIO_EN
        gnt0 = 1'b1;
`else
        if (ptr) gnt1 = 1'b1;
        else     gnt0 = 1'b1;
`endif
      end else if (bus.req0) begin
        gnt0 = 1'b1;
      end else if (bus.req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Control state: valids, priority pointer and completed-transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      count  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      ptr    <= 1'b0;
`endif
    end else begin
      if (vld_p2 && bus.out_ready) count <= count + 1'b1;
      if (advance) vld_p2 <= vld_p1;
      if (accept)  vld_p1 <= gnt_any;
`ifndef ARB_FIXED_PRIO_EN
      // After any granted transfer the other requester gets the next conflict
      if (gnt_any) ptr <= !gnt1;
`endif
    end
  end

  // Datapath: stage 2 takes the pre-edge stage 1 contents; stage 1 loads the
  // winner's sample and holds its data/tag when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_p1  <= 1'b0;
      data_p1 <= S1_RST;
      tag_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      // ---- stage 1 -> stage 2 ----
      if (advance) begin
        tag_p2  <= tag_p1;
        data_p2 <= data_p1;
      end
      // ---- requesters -> stage 1 ----
      if (gnt_any) begin
        tag_p1  <= gnt1;
        data_p1 <= gnt1 ? bus.in1 : bus.in0;
      end
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_tag   = tag_p2;
  assign bus.out_count = count;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with a scoreboard queue: every grant
// predicted by the reference model pushes {tag,data}; every predicted output
// transfer pops and compares.
module tb_pipe_share_arbiter;

  logic clk;
  logic rst;

  pipe_share_arbiter_if #(.DW(4), .CNT_W(8)) bus();

  pipe_share_arbiter #(.DW(4), .CNT_W(8), .S1_RST(4'd7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_v1, m_v2, m_ptr;
  logic [7:0] m_cnt;
  logic [4:0] q[$];

  // Values observed in the most recent cycle() call
  logic       obs_g0, obs_g1, obs_vld, obs_tag;
  logic [3:0] obs_data, obs_s1;
  logic [7:0] obs_cnt;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: sample at negedge, check against model, advance model, edge
  task automatic cycle();
    logic adv, acc, eg0, eg1;
    logic [4:0] item;
    @(negedge clk);
    obs_g0   = bus.gnt0;
    obs_g1   = bus.gnt1;
    obs_vld  = bus.out_valid;
    obs_data = bus.out_data;
    obs_tag  = bus.out_tag;
    obs_cnt  = bus.out_count;
    obs_s1   = dut.data_p1;
    adv = !m_v2 || bus.out_ready;
    acc = !m_v1 || adv;
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (acc) begin
      if (bus.req0 && bus.req1) begin
`ifdef ARB_FIXED_PRIO_EN
        eg0 = 1'b1;
`else
        if (m_ptr) eg1 = 1'b1;
        else       eg0 = 1'b1;
`endif
      end else if (bus.req0) eg0 = 1'b1;
      else if (bus.req1)     eg1 = 1'b1;
    end
    chk("gnt0", 32'(obs_g0), 32'(eg0));
    chk("gnt1", 32'(obs_g1), 32'(eg1));
    chk("out_valid", 32'(obs_vld), 32'(m_v2));
    chk("out_count", 32'(obs_cnt), 32'(m_cnt));
    if (m_v2 && bus.out_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'(1));
      if (q.size() != 0) begin
        item = q.pop_front();
        chk("out_data", 32'(obs_data), 32'(item[3:0]));
        chk("out_tag", 32'(obs_tag), 32'(item[4]));
      end
      m_cnt = m_cnt + 8'd1;
    end
    if (adv) m_v2 = m_v1;
    if (acc) m_v1 = eg0 || eg1;
    if (eg0 || eg1) begin
      q.push_back({eg1, eg1 ? bus.in1 : bus.in0});
      m_ptr = !eg1;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge; grants must stay low while rst is high
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 32'(0));
    chk("rst_gnt1", 32'(bus.gnt1), 32'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    m_v1  = 1'b0;
    m_v2  = 1'b0;
    m_ptr = 1'b0;
    m_cnt = 8'd0;
    q.delete();
  endtask

  initial begin
    logic exp_g0;
    int   guard;
    rst = 1'b1;
    bus.req0 = 1'b0; bus.in0 = 4'h0;
    bus.req1 = 1'b0; bus.in1 = 4'h0;
    bus.out_ready = 1'b0;

    // 1. Reset then idle
    do_reset();
    cycle();
    cycle();
    chk("t1_s1_data", 32'(obs_s1), 32'(7));
    chk("t1_out_valid", 32'(obs_vld), 32'(0));
    chk("t1_out_count", 32'(obs_cnt), 32'(0));
    chk("t1_gnt", 32'({obs_g0, obs_g1}), 32'(0));

    // 2. Single req0 sample 0xA
    bus.out_ready = 1'b1;
    bus.req0 = 1'b1; bus.in0 = 4'hA;
    cycle();
    chk("t2_gnt0", 32'(obs_g0), 32'(1));
    bus.req0 = 1'b0;
    cycle();
    chk("t2_not_yet", 32'(obs_vld), 32'(0));
    cycle();
    chk("t2_valid", 32'(obs_vld), 32'(1));
    chk("t2_data", 32'(obs_data), 32'hA);
    chk("t2_tag", 32'(obs_tag), 32'(0));
    cycle();
    chk("t2_count", 32'(obs_cnt), 32'(1));

    // 3. Both requesting: alternate grants
    do_reset();
    bus.out_ready = 1'b1;
    bus.req0 = 1'b1; bus.in0 = 4'h1;
    bus.req1 = 1'b1; bus.in1 = 4'h2;
    for (int i = 0; i < 6; i++) begin
      cycle();
`ifdef ARB_FIXED_PRIO_EN
      exp_g0 = 1'b1;
`else
      exp_g0 = (i % 2 == 0);
`endif
      chk("t3_gnt0_seq", 32'(obs_g0), 32'(exp_g0));
      if (i >= 2) begin
`ifdef ARB_FIXED_PRIO_EN
        chk("t3_out_seq", 32'(obs_data), 32'h1);
`else
        chk("t3_out_seq", 32'(obs_data), (i % 2 == 0) ? 32'h1 : 32'h2);
        chk("t3_tag_seq", 32'(obs_tag), (i % 2 == 0) ? 32'(0) : 32'(1));
`endif
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cycle();
    cycle();
    cycle();

    // 4. Fill pipe under backpressure, hold, then release
    do_reset();
    bus.out_ready = 1'b0;
    bus.req0 = 1'b1; bus.in0 = 4'h3;
    cycle();
    bus.in0 = 4'h5;
    cycle();
    bus.in0 = 4'h9;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("t4_hold_data", 32'(obs_data), 32'h3);
      chk("t4_hold_gnt0", 32'(obs_g0), 32'(0));
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("t4_rel_first", 32'(obs_data), 32'h3);
    chk("t4_rel_gnt0", 32'(obs_g0), 32'(1));
    bus.req0 = 1'b0;
    cycle();
    chk("t4_rel_second", 32'(obs_data), 32'h5);
    cycle();
    chk("t4_rel_third", 32'(obs_data), 32'h9);
    cycle();

    // 5. Counter wrap after 256 transfers
    do_reset();
    bus.out_ready = 1'b1;
    bus.req0 = 1'b1;
    guard = 0;
    obs_cnt = 8'd0;
    while (obs_cnt != 8'd255 && guard < 400) begin
      bus.in0 = 4'($urandom_range(0, 15));
      cycle();
      guard++;
    end
    chk("t5_reached_255", 32'(obs_cnt), 32'(255));
    cycle();
    chk("t5_wrap", 32'(obs_cnt), 32'(0));

    // 6. Reset while both stages hold valid data
    bus.out_ready = 1'b0;
    bus.req0 = 1'b0;
    cycle();
    cycle();
    bus.req0 = 1'b1; bus.in0 = 4'hC;
    cycle();
    cycle();
    chk("t6_full", 32'({obs_vld, dut.vld_p1}), 32'(3));
    bus.out_ready = 1'b1;
    do_reset();
    cycle();
    chk("t6_out_valid", 32'(obs_vld), 32'(0));
    chk("t6_s1_data", 32'(obs_s1), 32'(7));
    chk("t6_count", 32'(obs_cnt), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
